ifetch_seq: RTL

//  Instruction fetch sequencer for the single-issue MIPS core. Owns the PC.

---
 rtl/ifetch_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/ifetch_seq.sv
// Instruction fetch sequencer: owns the PC, fetches one word per instruction
// over imem req/ack, holds it for decode, and forms the next PC from NPCOp.
module ifetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_accept,
    input  logic [1:0]  NPCOp,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err,
    output logic [1:0]  state_dbg
);

    // Handshakes: imem_req/imem_addr stay asserted and stable until a cycle
    // with imem_ack=1 (ack is ignored unless req is high). instr_valid stays
    // high with instr/pc stable until a cycle with instr_accept=1, which
    // retires the word; accept is ignored while instr_valid is low.
    typedef enum logic [1:0] {
        RESET_GAP = 2'd0,
        FETCH     = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t      state, state_next;
    logic        gap_done;
    logic [7:0]  timer;
    logic [31:0] next_pc;
    logic        fetch_done;
    logic        retire;

    assign fetch_done = (state == FETCH) && imem_ack;
    assign retire     = (state == HOLD) && instr_accept;
    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RESET_GAP;
        end else begin
            state <= state_next;
        end
    end

    // gap_done makes RESET_GAP last a full cycle after the synchronous release.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            RESET_GAP: begin
                if (gap_done) state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_next = HOLD;
            end
            HOLD: begin
                if (instr_accept) state_next = FETCH;
            end
            default: state_next = RESET_GAP;
        endcase
    end

    always_comb begin
        next_pc = pc_plus4;
        case (NPCOp)
            2'b01:   next_pc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
            2'b10:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gap_done    <= 1'b0;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            timer       <= 8'd0;
        end else begin
            gap_done <= 1'b1;
            if (fetch_done) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            // Timer saturates at TIMEOUT; the request keeps going after the error.
            if ((state == FETCH) && !imem_ack && (timer != TIMEOUT)) begin
                timer <= timer + 8'd1;
            end
            if ((state == FETCH) && (timer == TIMEOUT)) begin
                fetch_err <= 1'b1;
            end
            if (retire) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
                timer       <= 8'd0;
                if (NPCOp == 2'b11) fetch_err <= 1'b1;
            end
        end
    end

endmodule
